// File: rtl/mem_sync_ctrl.sv
// mem_sync_ctrl: single-port RAM with 1-cycle registered read, byte-lane writes and a hardware clear sequencer.
// Optional per-lane even parity (inj_par / par_err ports) is compiled in when MEM_PARITY_EN is defined.
module mem_sync_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                rd,
  input  logic                wt,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy,
  output logic                err
`ifdef MEM_PARITY_EN
  ,
  input  logic                inj_par,
  output logic [DATA_W/8-1:0] par_err
`endif
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
  logic [DATA_W-1:0]   r_data_out;
  logic                r_rd_valid;
  logic                r_err;

  logic                w_idle;
  logic                w_clr_we;
  logic                w_last;
  logic                w_in_range;
  logic                w_req;
  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_bad;

  assign w_idle     = (r_state == S_IDLE);
  assign w_clr_we   = (r_state == S_CLEAR);
  assign w_last     = (r_ptr == ADDR_W'(MEM_DEPTH - 1));
  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  assign w_in_range = ({1'b0, addr} < (ADDR_W + 1)'(MEM_DEPTH));
  // clr in the same cycle as a request takes priority and drops the request.
  assign w_req      = w_idle & ~clr & cs;
  assign w_wr_ok    = w_req & wt & ~rd & w_in_range;
  assign w_rd_ok    = w_req & rd & ~wt & w_in_range;
  assign w_bad      = w_req & (rd | wt) & ~(w_wr_ok | w_rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        if (clr) begin
          w_ptr_nxt = '0;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Storage array carries no reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_ptr] <= CLR_VAL;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      r_err      <= w_bad;
      if (w_rd_ok) begin
        r_data_out <= r_mem[addr];
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] r_par [MEM_DEPTH];
  logic [NB-1:0] r_par_err;
  logic [NB-1:0] w_wr_par;

  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int i = 0; i < NB; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Even parity per lane; inj_par flips the stored bit to fake a corrupted lane.
  assign w_wr_par = lane_par(data_in) ^ {NB{inj_par}};

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[r_ptr] <= lane_par(CLR_VAL);
    end else if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          r_par[addr][i] <= w_wr_par[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_err <= '0;
    end else if (w_rd_ok) begin
      r_par_err <= lane_par(r_mem[addr]) ^ r_par[addr];
    end else begin
      r_par_err <= '0;
    end
  end

  assign par_err = r_par_err;
`endif

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;
  assign busy     = w_clr_we;

endmodule

// File: tb/tb_mem_sync_ctrl.sv
// Bench for mem_sync_ctrl (MEM_DEPTH=1000 so out-of-range addresses exist); compares against an array model.
module tb_mem_sync_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1000;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cs = 1'b0, rd = 1'b0, wt = 1'b0, clr = 1'b0, inj_par = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [NB-1:0]     be = '0;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid, busy, err;
  logic [NB-1:0]     par_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word array, per-lane "parity corrupted" flags, remaining clear cycles.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [NB-1:0]     m_bad [DEPTH];
  int                m_clear_left;
  logic [DATA_W-1:0] exp_dout;
  logic              exp_rv, exp_err;
  logic [NB-1:0]     exp_pe;

  mem_sync_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .CLR_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wt(wt), .addr(addr),
    .data_in(data_in), .be(be), .clr(clr),
    .data_out(data_out), .rd_valid(rd_valid), .busy(busy), .err(err)
`ifdef MEM_PARITY_EN
    , .inj_par(inj_par), .par_err(par_err)
`endif
  );

`ifndef MEM_PARITY_EN
  assign par_err = '0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_start_clear();
    m_clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = '0;
    end
  endtask

  task automatic model_reset();
    exp_dout = '0;
    exp_rv   = 1'b0;
    exp_err  = 1'b0;
    exp_pe   = '0;
    model_start_clear();
  endtask

  // Drives one request for one rising edge and advances the model; returns at posedge+1.
  task automatic step(input logic c, input logic r, input logic w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [NB-1:0] b, input logic cl, input logic ip);
    @(negedge clk);
    cs = c; rd = r; wt = w; addr = a; data_in = d; be = b; clr = cl; inj_par = ip;
    exp_rv = 1'b0; exp_err = 1'b0; exp_pe = '0;
    if (m_clear_left > 0) begin
      if (cl) m_clear_left = DEPTH;
      else    m_clear_left = m_clear_left - 1;
    end else if (cl) begin
      model_start_clear();
    end else if (c && (r || w)) begin
      if ((r && w) || int'(a) >= DEPTH) begin
        exp_err = 1'b1;
      end else if (w) begin
        for (int i = 0; i < NB; i++) begin
          if (b[i]) begin
            m_mem[a][8*i +: 8] = d[8*i +: 8];
`ifdef MEM_PARITY_EN
            m_bad[a][i] = ip;
`endif
          end
        end
      end else begin
        exp_rv   = 1'b1;
        exp_dout = m_mem[a];
        exp_pe   = m_bad[a];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic release_and_count(input string tag);
    int n;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < DEPTH + 20) begin
      idle();
      n++;
    end
    n_tests++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", tag, n, DEPTH);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL reset_busy: got %b required 1", busy); end
    n_tests++; if (data_out !== '0)   begin n_fail++; $display("FAIL reset_data_out: got %h required 0", data_out); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
    n_tests++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    release_and_count("reset");
    step(1'b1, 1'b1, 1'b0, 10'd5, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_read5: got rv=%b data=%h required rv=1 data=0", rd_valid, data_out);
    end
    idle();
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read5_pulse: got rv=%b required 0", rd_valid); end
  endtask

  task automatic test_byte_lanes();
    step(1'b1, 1'b0, 1'b1, 10'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'd3, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd3, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'hAA22CC44 || exp_dout !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL byte_lanes: got rv=%b data=%h required rv=1 data=AA22CC44", rd_valid, data_out);
    end
    idle();
    n_tests++; if (rd_valid !== 1'b0 || data_out !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL byte_lanes_hold: got rv=%b data=%h required rv=0 data=AA22CC44", rd_valid, data_out);
    end
    step(1'b1, 1'b0, 1'b1, 10'd4, 32'hDEADBEEF, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd4, '0, '0, 1'b0, 1'b0);
    n_tests++; if (data_out !== exp_dout || err !== 1'b0) begin
      n_fail++; $display("FAIL be_zero_noop: got data=%h err=%b required data=%h err=0", data_out, err, exp_dout);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b1, 10'd10, 32'h12345678, 4'hF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd10, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'h12345678) begin
      n_fail++; $display("FAIL raw_b2b: got rv=%b data=%h required rv=1 data=12345678", rd_valid, data_out);
    end
    step(1'b1, 1'b1, 1'b1, 10'd10, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdwt_err: got err=%b rv=%b required err=1 rv=0", err, rd_valid);
    end
    step(1'b1, 1'b1, 1'b0, 10'd10, '0, '0, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b0 || data_out !== 32'h12345678) begin
      n_fail++; $display("FAIL rdwt_unchanged: got err=%b data=%h required err=0 data=12345678", err, data_out);
    end
  endtask

  task automatic test_range();
    step(1'b1, 1'b0, 1'b1, 10'd1010, 32'h55AA55AA, 4'hF, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_write_err: got %b required 1", err); end
    step(1'b1, 1'b0, 1'b1, 10'd999, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL last_write_err: got %b required 0", err); end
    step(1'b1, 1'b1, 1'b0, 10'd999, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL read_999: got rv=%b data=%h required rv=1 data=CAFEF00D", rd_valid, data_out);
    end
    step(1'b1, 1'b1, 1'b0, 10'd1000, '0, '0, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b1 || rd_valid !== 1'b0 || data_out !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL oor_read_1000: got err=%b rv=%b data=%h required err=1 rv=0 data=CAFEF00D", err, rd_valid, data_out);
    end
    step(1'b0, 1'b1, 1'b1, 10'd1023, '0, '0, 1'b0, 1'b0);
    n_tests++; if (err !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL cs_low: got err=%b rv=%b required 0 0", err, rd_valid);
    end
  endtask

  task automatic test_random();
    logic c, r, w;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < 400; k++) begin
      c = ($urandom_range(7) != 0);
      r = $urandom_range(1);
      w = $urandom_range(1);
      a = ($urandom_range(9) == 0) ? ADDR_W'($urandom_range(1023, 990)) : ADDR_W'($urandom_range(31));
      step(c, r, w, a, $urandom, NB'($urandom), 1'b0, 1'b0);
      n_tests++;
      if (rd_valid !== exp_rv || err !== exp_err || data_out !== exp_dout || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d]: got rv=%b err=%b data=%h busy=%b required rv=%b err=%b data=%h busy=0",
                 k, rd_valid, err, data_out, busy, exp_rv, exp_err, exp_dout);
      end
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    step(1'b1, 1'b1, 1'b0, 10'd3, '0, '0, 1'b1, 1'b0);
    n_tests++; if (busy !== 1'b1 || rd_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL clr_wins: got busy=%b rv=%b err=%b required 1 0 0", busy, rd_valid, err);
    end
    step(1'b1, 1'b1, 1'b0, 10'd3, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 10'd1010, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL busy_drop: got rv=%b err=%b required 0 0", rd_valid, err);
    end
    repeat (400) idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < DEPTH + 20) begin
      idle();
      n++;
    end
    n_tests++; if (n !== DEPTH) begin n_fail++; $display("FAIL clr_restart_cycles: got %0d required %0d", n, DEPTH); end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, 1'b1, 1'b0, ADDR_W'(a), '0, '0, 1'b0, 1'b0);
      if (rd_valid !== 1'b1 || data_out !== 32'h0 || data_out !== exp_dout || par_err !== '0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clear_all_zero: got %0d bad words required 0", bad); end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    step(1'b1, 1'b0, 1'b1, 10'd7, 32'h0F0F1234, 4'b0010, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 10'd7, '0, '0, 1'b0, 1'b0);
    n_tests++; if (par_err !== 4'b0010 || exp_pe !== 4'b0010 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL par_inject: got par_err=%b rv=%b required 0010 1", par_err, rd_valid);
    end
    idle();
    n_tests++; if (par_err !== 4'b0000) begin n_fail++; $display("FAIL par_idle_zero: got %b required 0000", par_err); end
    step(1'b1, 1'b0, 1'b1, 10'd7, 32'h0F0F5634, 4'b0010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd7, '0, '0, 1'b0, 1'b0);
    n_tests++; if (par_err !== 4'b0000 || data_out !== exp_dout) begin
      n_fail++; $display("FAIL par_rewrite: got par_err=%b data=%h required 0000 %h", par_err, data_out, exp_dout);
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    step(1'b1, 1'b0, 1'b1, 10'd20, 32'h0BADC0DE, 4'hF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'd20, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'h0BADC0DE) begin
      n_fail++; $display("FAIL mid_read_pre: got rv=%b data=%h required 1 0BADC0DE", rd_valid, data_out);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (rd_valid !== 1'b0 || data_out !== 32'h0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_read_cancel: got rv=%b data=%h busy=%b required 0 0 1", rd_valid, data_out, busy);
    end
    cs = 1'b0; rd = 1'b0;
    release_and_count("mid_read");
    step(1'b1, 1'b0, 1'b1, 10'd20, 32'h13579BDF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wt = 1'b0; addr = 10'd20;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_tests++; if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_reset: got rv=%b busy=%b required 0 1", rd_valid, busy);
    end
    cs = 1'b0; rd = 1'b0;
    release_and_count("same_cycle");
    step(1'b1, 1'b1, 1'b0, 10'd20, '0, '0, 1'b0, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || data_out !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_read: got rv=%b data=%h required 1 0", rd_valid, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_range();
    test_random();
    test_clear();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sync_ctrl.md
Name: mem_sync_ctrl

Overview:
- Parametrised synchronous single-port RAM with a registered read path, byte-lane write enables and a hardware clear sequencer.
- Replaces the earlier level-sensitive, unclocked memory with the same cs/rd/wt control style.
- Sits behind any master in the design that needs scratch storage; all timing is referenced to one clock.

Parameters:
- ADDR_W, 10, address width in bits.
- DATA_W, 32, word width in bits; must be a multiple of 8.
- MEM_DEPTH, 1024, number of words; must be ≤ 2^ADDR_W.
- CLR_VAL, 0, value written to every word by the clear sequence.

Ports:
- clk  input  1  single clock; all logic samples on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  chip select; a request is considered only when cs=1.
- rd  input  1  read request.
- wt  input  1  write request.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- be  input  DATA_W/8  byte-lane write enables; bit i covers data_in[8i+7:8i].
- clr  input  1  start the clear sequence; single-cycle pulse.
- data_out  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse; data_out is valid in that cycle.
- busy  output  1  clear in progress; requests are ignored while high.
- err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data_out=0, rd_valid=0, err=0.
  - FSM forced to CLEAR with the clear pointer at 0, so busy=1 while reset is held.
  - Memory contents are not reset directly; the clear sequence overwrites them.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes CLR_VAL to mem[ptr] each cycle, ptr increments. When ptr=MEM_DEPTH-1 is written, go to IDLE next cycle.
  - A full clear takes exactly MEM_DEPTH cycles after rst_n rises; busy=1 throughout.
  - IDLE: busy=0. A clr pulse sets ptr=0 and returns to CLEAR.
  - clr in CLEAR restarts the sequence from ptr=0.
- Request decode, IDLE only, evaluated each rising edge:
  - cs=1, wt=1, rd=0, addr<MEM_DEPTH: for each i with be[i]=1, byte i of mem[addr] ← byte i of data_in; other lanes unchanged. be=0 is a legal no-op.
  - cs=1, rd=1, wt=0, addr<MEM_DEPTH: data_out ← mem[addr]; rd_valid=1 in the next cycle. Read latency is 1 cycle.
  - cs=1, rd=1, wt=1: no access; err pulses next cycle.
  - cs=1, rd or wt, addr≥MEM_DEPTH: no access; err pulses next cycle.
  - cs=0: no access regardless of rd/wt.
- Back-to-back accesses:
  - A read one cycle after a write to the same address returns the new data.
  - One request per cycle, sustained.
- data_out holds its last read value until the next successful read; only rd_valid marks freshness.
- Requests with busy=1 are dropped silently: no err, no rd_valid.
- clr and a request in the same IDLE cycle: clr wins and the request is dropped.
- Reset asserted mid-clear or mid-read: the in-flight rd_valid is cancelled and the clear restarts from 0 after reset releases.

Optional Feature:
- Macro MEM_PARITY_EN.
- When defined:
  - Each byte lane stores an extra even-parity bit, written with its byte.
  - Extra ports: inj_par (input, 1) inverts the stored parity of every enabled lane on that write; par_err (output, DATA_W/8) is valid with rd_valid and has bit i set when lane i fails parity, 0 otherwise.
  - The clear sequence writes correct parity. par_err resets to 0.
- When not defined: no parity storage and no inj_par/par_err ports; behaviour is otherwise identical.

Test Plan:
- Release rst_n, MEM_DEPTH=1024 → busy=1 for exactly 1024 cycles, then 0; a read of addr 5 returns 0 with rd_valid one cycle after the request.
- Write addr 3 data 0xAABBCCDD be=4'b1111, then write addr 3 data 0x11223344 be=4'b0101, then read addr 3 → data_out=0xAA22CC44, rd_valid exactly 1 cycle.
- Write addr 10 = 0x12345678, read addr 10 next cycle → 0x12345678 on the following cycle. cs=1, rd=1, wt=1 → err pulses once; memory unchanged.
- MEM_DEPTH=1000, ADDR_W=10: write addr 1010 → err pulse; read addr 999 works. Issue clr, then a request during busy → no rd_valid, no err; after 1000 cycles every address reads 0.
- MEM_PARITY_EN: write addr 7 with inj_par=1, be=4'b0010, then read addr 7 → par_err=4'b0010. Rewrite with inj_par=0 → par_err=0.
- Assert rst_n low in the same cycle as a read request → rd_valid stays 0 and the clear restarts from ptr 0.
